// File: rtl/cmp_branch_resolver_if.sv
// Bus between the control unit / CMP16bit side and the branch resolver.
// The master side issues compares, supplies the compare result and raises
// branch requests. The slave side (the resolver) answers with ack/taken/err.
interface cmp_branch_resolver_if #(
    parameter int WIDTH = 16
);
    logic             cmp_issue;
    logic [WIDTH-1:0] cmp_op1;
    logic [WIDTH-1:0] cmp_op2;
    logic [WIDTH-1:0] cmp_result;
    logic             br_req;
    logic [3:0]       br_cond;
    logic             br_ack;
    logic             br_taken;
    logic             cond_err;

    modport master (
        output cmp_issue,
        output cmp_op1,
        output cmp_op2,
        output cmp_result,
        output br_req,
        output br_cond,
        input  br_ack,
        input  br_taken,
        input  cond_err
    );

    modport slave (
        input  cmp_issue,
        input  cmp_op1,
        input  cmp_op2,
        input  cmp_result,
        input  br_req,
        input  br_cond,
        output br_ack,
        output br_taken,
        output cond_err
    );
endinterface

// File: rtl/cmp_branch_resolver.sv
// Branch resolver sitting behind the CMP16bit compare unit.
// Tracks in-flight compares with their operands, turns each completing
// compare result into Z/N/C/V flags, and answers branch-condition requests
// once no compare is still in flight, so a branch always sees the newest flags.
module cmp_branch_resolver #(
    parameter int WIDTH   = 16,
    parameter int CMP_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cmp_branch_resolver_if.slave bus,
    output logic [3:0]           o_flags,
    output logic                 o_flags_valid,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_taken_cnt
);

    localparam logic [3:0] COND_EQ  = 4'd0;
    localparam logic [3:0] COND_NE  = 4'd1;
    localparam logic [3:0] COND_LTU = 4'd2;
    localparam logic [3:0] COND_GEU = 4'd3;
    localparam logic [3:0] COND_LT  = 4'd4;
    localparam logic [3:0] COND_GE  = 4'd5;
    localparam logic [3:0] COND_GT  = 4'd6;
    localparam logic [3:0] COND_LE  = 4'd7;
    localparam logic [3:0] COND_GTU = 4'd8;
    localparam logic [3:0] COND_LEU = 4'd9;
    localparam logic [3:0] COND_AL  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [CMP_LAT-1:0] r_pipeValid;
    logic [WIDTH-1:0]   r_pipeOp1 [CMP_LAT];
    logic [WIDTH-1:0]   r_pipeOp2 [CMP_LAT];

    logic [3:0]         r_flags;
    logic               r_flagsValid;
    logic [CNT_W-1:0]   r_takenCnt;

    logic               w_tailValid;
    logic [WIDTH-1:0]   w_tailOp1;
    logic [WIDTH-1:0]   w_tailOp2;
    logic [3:0]         w_newFlags;
    logic               w_upstreamBusy;
    logic               w_drainNext;
    logic               w_condTaken;
    logic               w_condErr;
    logic               w_ack;
    logic               w_taken;
    logic               w_err;
    logic               w_flagZ;
    logic               w_flagN;
    logic               w_flagC;
    logic               w_flagV;
    logic               w_signedLess;

    assign w_tailValid = r_pipeValid[CMP_LAT-1];
    assign w_tailOp1   = r_pipeOp1[CMP_LAT-1];
    assign w_tailOp2   = r_pipeOp2[CMP_LAT-1];

    // Operand pipeline: one slot per cycle of CMP latency, the tail lines up with cmp_result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pipeValid <= '0;
            for (int i = 0; i < CMP_LAT; i++) begin
                r_pipeOp1[i] <= '0;
                r_pipeOp2[i] <= '0;
            end
        end else begin
            r_pipeValid[0] <= bus.cmp_issue;
            r_pipeOp1[0]   <= bus.cmp_op1;
            r_pipeOp2[0]   <= bus.cmp_op2;
            for (int i = 1; i < CMP_LAT; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                r_pipeOp1[i]   <= r_pipeOp1[i-1];
                r_pipeOp2[i]   <= r_pipeOp2[i-1];
            end
        end
    end

    // Flags for the compare completing this cycle; carry and overflow need the original operands.
    always_comb begin
        w_newFlags    = '0;
        w_newFlags[3] = (bus.cmp_result == '0);
        w_newFlags[2] = bus.cmp_result[WIDTH-1];
        w_newFlags[1] = (w_tailOp1 < w_tailOp2);
        w_newFlags[0] = (w_tailOp1[WIDTH-1] ^ w_tailOp2[WIDTH-1]) &
                        (w_tailOp1[WIDTH-1] ^ bus.cmp_result[WIDTH-1]);
    end

    // Flags register: the most recently completing compare always overwrites it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flags      <= '0;
            r_flagsValid <= 1'b0;
        end else if (w_tailValid) begin
            r_flags      <= w_newFlags;
            r_flagsValid <= 1'b1;
        end
    end

    // The pipeline is empty after this edge when only the tail (if anything) is occupied
    // and nothing new is issued; the tail's flags land on that same edge.
    always_comb begin
        w_upstreamBusy = 1'b0;
        for (int i = 0; i < CMP_LAT - 1; i++) begin
            w_upstreamBusy = w_upstreamBusy | r_pipeValid[i];
        end
        w_drainNext = !w_upstreamBusy && !bus.cmp_issue;
    end

    // Condition evaluation against the registered flags; codes above AL are reserved.
    always_comb begin
        w_flagZ      = r_flags[3];
        w_flagN      = r_flags[2];
        w_flagC      = r_flags[1];
        w_flagV      = r_flags[0];
        w_signedLess = w_flagN ^ w_flagV;
        w_condTaken  = 1'b0;
        w_condErr    = 1'b0;
        case (bus.br_cond)
            COND_EQ:  w_condTaken = w_flagZ;
            COND_NE:  w_condTaken = !w_flagZ;
            COND_LTU: w_condTaken = w_flagC;
            COND_GEU: w_condTaken = !w_flagC;
            COND_LT:  w_condTaken = w_signedLess;
            COND_GE:  w_condTaken = !w_signedLess;
            COND_GT:  w_condTaken = !w_flagZ && !w_signedLess;
            COND_LE:  w_condTaken = w_flagZ || w_signedLess;
            COND_GTU: w_condTaken = !w_flagC && !w_flagZ;
            COND_LEU: w_condTaken = w_flagC || w_flagZ;
            COND_AL:  w_condTaken = 1'b1;
            default:  w_condErr   = 1'b1;
        endcase
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Handshake next state and ack outputs; a request waits until no compare is in flight.
    always_comb begin
        w_nextState = r_state;
        w_ack       = 1'b0;
        w_taken     = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.br_req) begin
                    w_nextState = w_drainNext ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_drainNext) begin
                    w_nextState = S_ACK;
                end
            end
            S_ACK: begin
                w_ack       = 1'b1;
                w_taken     = w_condTaken;
                w_err       = w_condErr;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Taken-branch counter, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_takenCnt <= '0;
        end else if (w_ack && w_taken) begin
            r_takenCnt <= r_takenCnt + CNT_W'(1);
        end
    end

    assign bus.br_ack    = w_ack;
    assign bus.br_taken  = w_taken;
    assign bus.cond_err  = w_err;
    assign o_flags       = r_flags;
    assign o_flags_valid = r_flagsValid;
    assign o_busy        = |r_pipeValid;
    assign o_taken_cnt   = r_takenCnt;

endmodule

// File: tb/tb_cmp_branch_resolver.sv
// Testbench for cmp_branch_resolver: directed compares and branch requests,
// a cycle-level reference model of flags/busy/ack timing and a per-cycle compare.
module tb_cmp_branch_resolver;

    localparam int WIDTH   = 16;
    localparam int CMP_LAT = 1;
    localparam int CNT_W   = 16;

    typedef struct {
        int               doneEdge;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } issue_t;

    logic             clk;
    logic             rst;
    logic [3:0]       flags;
    logic             flagsValid;
    logic             busy;
    logic [CNT_W-1:0] takenCnt;

    int checkCount = 0;
    int errorCount = 0;

    issue_t           inflight [$];
    int               edgeN = 0;
    bit               modelReady = 0;
    bit               haveCmp = 0;
    logic [WIDTH-1:0] lastA = '0;
    logic [WIDTH-1:0] lastB = '0;
    logic             mAck = 0;
    logic             mTaken = 0;
    logic             mErr = 0;
    logic [CNT_W-1:0] mCnt = '0;
    logic             cntPresetReq = 0;

    logic [WIDTH-1:0] resPipe [CMP_LAT];

    cmp_branch_resolver_if #(.WIDTH(WIDTH)) bus ();

    cmp_branch_resolver #(
        .WIDTH   (WIDTH),
        .CMP_LAT (CMP_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .o_flags       (flags),
        .o_flags_valid (flagsValid),
        .o_busy        (busy),
        .o_taken_cnt   (takenCnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for CMP16bit: op1-op2 delayed by CMP_LAT cycles.
    always @(posedge clk) begin
        resPipe[0] <= bus.cmp_op1 - bus.cmp_op2;
        for (int i = 1; i < CMP_LAT; i++) begin
            resPipe[i] <= resPipe[i-1];
        end
    end
    assign bus.cmp_result = resPipe[CMP_LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic issue, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic req, input logic [3:0] cond);
        bus.cmp_issue = issue;
        bus.cmp_op1   = a;
        bus.cmp_op2   = b;
        bus.br_req    = req;
        bus.br_cond   = cond;
    endtask

    // Flags implied by the last completed compare, derived from the operand values.
    function automatic logic [3:0] modelFlags();
        logic [WIDTH-1:0] r;
        int               d;
        if (!haveCmp) return 4'b0000;
        r = lastA - lastB;
        d = int'($signed(lastA)) - int'($signed(lastB));
        return {lastA == lastB, r[WIDTH-1], lastA < lastB, (d > 32767) || (d < -32768)};
    endfunction

    // Branch outcome from operand relations; before any compare the reset flags read as "not equal, not less".
    function automatic logic modelCond(input logic [3:0] cond);
        logic eq;
        logic ltu;
        logic lts;
        eq  = haveCmp && (lastA == lastB);
        ltu = haveCmp && (lastA < lastB);
        lts = haveCmp && ($signed(lastA) < $signed(lastB));
        case (cond)
            4'd0:    return eq;
            4'd1:    return !eq;
            4'd2:    return ltu;
            4'd3:    return !ltu;
            4'd4:    return lts;
            4'd5:    return !lts;
            4'd6:    return !lts && !eq;
            4'd7:    return lts || eq;
            4'd8:    return !ltu && !eq;
            4'd9:    return ltu || eq;
            4'd10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model advanced once per rising edge from the sampled inputs.
    task automatic modelStep();
        logic newAck;
        if (!rst) begin
            inflight.delete();
            haveCmp = 0;
            mAck    = 0;
            mTaken  = 0;
            mErr    = 0;
            mCnt    = '0;
        end else begin
            if (mAck && mTaken) mCnt = mCnt + 1'b1;
            if (cntPresetReq) mCnt = 16'hFFFE;
            while (inflight.size() > 0 && inflight[0].doneEdge == edgeN) begin
                lastA   = inflight[0].a;
                lastB   = inflight[0].b;
                haveCmp = 1;
                void'(inflight.pop_front());
            end
            if (bus.cmp_issue) begin
                issue_t e;
                e.doneEdge = edgeN + CMP_LAT;
                e.a        = bus.cmp_op1;
                e.b        = bus.cmp_op2;
                inflight.push_back(e);
            end
            newAck = bus.br_req && !mAck && (inflight.size() == 0);
            mAck   = newAck;
            mTaken = newAck && modelCond(bus.br_cond);
            mErr   = newAck && (bus.br_cond >= 4'd11);
        end
        edgeN++;
        modelReady = 1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Every cycle, away from the rising edge, all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (modelReady) begin
                checkOutput("flags",       flags,        modelFlags());
                checkOutput("flags_valid", flagsValid,   haveCmp);
                checkOutput("busy",        busy,         inflight.size() != 0);
                checkOutput("br_ack",      bus.br_ack,   mAck);
                checkOutput("br_taken",    bus.br_taken, mTaken);
                checkOutput("cond_err",    bus.cond_err, mErr);
                checkOutput("taken_cnt",   takenCnt,     mCnt);
            end
        end
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doBranch(input logic [3:0] cond, input logic expTaken, input logic expErr,
                            input int expLat, input string tag);
        int lat;
        lat = 0;
        bus.br_req  = 1'b1;
        bus.br_cond = cond;
        do begin
            tick();
            lat++;
        end while (!bus.br_ack && lat < 20);
        checkOutput({tag, "_lat"},   lat,          expLat);
        checkOutput({tag, "_taken"}, bus.br_taken, expTaken);
        checkOutput({tag, "_err"},   bus.cond_err, expErr);
        bus.br_req = 1'b0;
        tick();
    endtask

    task automatic issueCmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        applyStimulus(1'b1, a, b, 1'b0, 4'd0);
        tick();
        bus.cmp_issue = 1'b0;
        repeat (CMP_LAT) tick();
    endtask

    // Directed scenarios with hand-computed expectations.
    initial begin
        int lat;
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 4'd0);
        tick();
        tick();
        checkOutput("rst_flags",      flags,      4'h0);
        checkOutput("rst_flagsValid", flagsValid, 1'b0);
        checkOutput("rst_busy",       busy,       1'b0);
        checkOutput("rst_ack",        bus.br_ack, 1'b0);
        checkOutput("rst_cnt",        takenCnt,   16'h0000);
        rst = 1'b1;
        tick();

        doBranch(4'd10, 1'b1, 1'b0, 1, "al_reset");
        doBranch(4'd0,  1'b0, 1'b0, 1, "eq_reset");

        issueCmp(16'h000B, 16'h000B);
        checkOutput("eq_flags",      flags,      4'b1000);
        checkOutput("eq_flagsValid", flagsValid, 1'b1);
        doBranch(4'd0, 1'b1, 1'b0, 1, "eq");
        doBranch(4'd1, 1'b0, 1'b0, 1, "ne");

        issueCmp(16'h8000, 16'h7FFF);
        checkOutput("sv_flags", flags, 4'b0001);
        doBranch(4'd4, 1'b1, 1'b0, 1, "lt");
        doBranch(4'd8, 1'b1, 1'b0, 1, "gtu");
        doBranch(4'd6, 1'b0, 1'b0, 1, "gt");

        applyStimulus(1'b1, 16'h0000, 16'hFFFF, 1'b1, 4'd2);
        tick();
        bus.cmp_issue = 1'b0;
        checkOutput("race_busy",     busy,       1'b1);
        checkOutput("race_earlyAck", bus.br_ack, 1'b0);
        tick();
        checkOutput("race_ack",   bus.br_ack,   1'b1);
        checkOutput("race_taken", bus.br_taken, 1'b1);
        checkOutput("race_flags", flags,        4'b0010);
        bus.br_req = 1'b0;
        tick();

        doBranch(4'd12, 1'b0, 1'b1, 1, "rsvd");
        checkOutput("rsvd_cnt", takenCnt, 16'd5);

        applyStimulus(1'b1, 16'h0005, 16'h0003, 1'b0, 4'd0);
        tick();
        bus.cmp_issue = 1'b0;
        doBranch(4'd2, 1'b0, 1'b0, 1, "ltu_late");
        checkOutput("late_cnt", takenCnt, 16'd5);

        applyStimulus(1'b1, 16'h0009, 16'h0001, 1'b1, 4'd5);
        tick();
        applyStimulus(1'b1, 16'h7000, 16'h0010, 1'b1, 4'd5);
        tick();
        applyStimulus(1'b1, 16'h0001, 16'h0002, 1'b1, 4'd5);
        tick();
        bus.cmp_issue = 1'b0;
        lat = 3;
        do begin
            tick();
            lat++;
        end while (!bus.br_ack && lat < 20);
        checkOutput("b2b_lat",   lat,          4);
        checkOutput("b2b_taken", bus.br_taken, 1'b0);
        checkOutput("b2b_flags", flags,        4'b0110);
        bus.br_req = 1'b0;
        tick();

        applyStimulus(1'b1, 16'h0003, 16'h0003, 1'b1, 4'd0);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 4'd0);
        tick();
        checkOutput("rstwait_ack",        bus.br_ack, 1'b0);
        checkOutput("rstwait_busy",       busy,       1'b0);
        checkOutput("rstwait_flags",      flags,      4'h0);
        checkOutput("rstwait_flagsValid", flagsValid, 1'b0);
        checkOutput("rstwait_cnt",        takenCnt,   16'h0000);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rstwait_noAck", bus.br_ack, 1'b0);

        @(negedge clk);
        #1;
        force dut.r_takenCnt = 16'hFFFE;
        cntPresetReq = 1'b1;
        @(posedge clk);
        #1;
        release dut.r_takenCnt;
        cntPresetReq = 1'b0;
        doBranch(4'd10, 1'b1, 1'b0, 1, "al_wrap1");
        checkOutput("wrap_ffff", takenCnt, 16'hFFFF);
        doBranch(4'd10, 1'b1, 1'b0, 1, "al_wrap2");
        checkOutput("wrap_zero", takenCnt, 16'h0000);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
